shader_tcache_dma: RTL and testbench

//  DMA producer for shader_tcache's write port: accepts a fill command (start texel, count) and a

---
 rtl/shader_pkg.sv | 15 +
 rtl/shader_tcache_dma_lane.sv | 27 ++
 rtl/shader_tcache_dma.sv | 134 +++++++++++++
 tb/tb_shader_tcache_dma.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shader_pkg.sv
// Shared texture-cache types: texel type, cache geometry and the DMA producer state encoding.
package shader_pkg;
  localparam int TCACHE_WIDTH = 8;
  localparam int NTEX         = TCACHE_WIDTH * TCACHE_WIDTH;

  typedef logic [3:0] texel_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    HOLD,
    DONE
  } state_t;
endpackage

// File: rtl/shader_tcache_dma_lane.sv
// One staging texel of the DMA image: data register plus its write-enable mask bit.
module shader_tcache_dma_lane
  import shader_pkg::*;
(
  input  logic   aclk,
  input  logic   aresetn,
  input  logic   we,
  input  logic   clr,
  input  texel_t din,
  output texel_t data,
  output logic   mask
);

  // Data survives mask clears so a later partial fill only overwrites what it touches.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data <= '0;
      mask <= 1'b0;
    end else if (we) begin
      data <= din;
      mask <= 1'b1;
    end else if (clr) begin
      mask <= 1'b0;
    end
  end

endmodule

// File: rtl/shader_tcache_dma.sv
// DMA producer for shader_tcache: stages a streamed texel fill, then issues one masked 4-cycle burst.
module shader_tcache_dma
  import shader_pkg::*;
#(
  parameter int TCACHE_SIZE = 3,
  parameter int WORD_TEXELS = 8
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2*TCACHE_SIZE-1:0]   cmd_start,
  input  logic [2*TCACHE_SIZE:0]     cmd_count,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [4*WORD_TEXELS-1:0]   s_data,
  input  logic                       tc_idle,
  output logic                       strobe,
  output logic                       dma_en,
  output texel_t                     dma_data [(2**TCACHE_SIZE)**2],
  output logic [(2**TCACHE_SIZE)**2-1:0] dma_mask,
  output logic                       busy,
  output logic                       done
);

  localparam int LANES = (2**TCACHE_SIZE)**2;
  localparam int IDX_W = 2*TCACHE_SIZE;
  localparam int REM_W = IDX_W + 1;
  localparam int SEL_W = (WORD_TEXELS > 1) ? $clog2(WORD_TEXELS) : 1;
  localparam logic [REM_W-1:0] WORD_N  = REM_W'(WORD_TEXELS);
  localparam logic [REM_W-1:0] LANES_N = REM_W'(LANES);
  localparam logic [IDX_W-1:0] PTR_STEP = IDX_W'(WORD_TEXELS);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] rem_after;
  logic [1:0]       hold_cnt;
  logic             beat;
  logic             mask_clr;

  assign beat      = s_valid & s_ready;
  assign rem_after = (rem > WORD_N) ? rem - WORD_N : '0;
  assign mask_clr  = (cmd_valid & cmd_ready) | ((state == HOLD) && (hold_cnt == 2'd3));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      ptr       <= '0;
      rem       <= '0;
      hold_cnt  <= '0;
      cmd_ready <= 1'b1;
      s_ready   <= 1'b0;
      strobe    <= 1'b0;
      dma_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      strobe <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ptr       <= cmd_start;
            rem       <= (cmd_count > LANES_N) ? LANES_N : cmd_count;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            if (cmd_count == '0) begin
              state <= DONE;
            end else begin
              state   <= FILL;
              s_ready <= 1'b1;
            end
          end
        end
        FILL: begin
          if (beat) begin
            ptr <= ptr + PTR_STEP;
            rem <= rem_after;
            if (rem_after == '0) begin
              s_ready <= 1'b0;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (tc_idle) begin
            strobe   <= 1'b1;
            dma_en   <= 1'b1;
            hold_cnt <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          // Four dma_en cycles track the cache's three-step state walk plus the strobe cycle.
          hold_cnt <= hold_cnt + 2'd1;
          if (hold_cnt == 2'd3) begin
            dma_en <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [IDX_W-1:0] off;
    logic             lane_we;
    texel_t           lane_din;

    // Offset of this texel from the beat's base pointer, wrapping modulo the cache size.
    assign off      = IDX_W'(i) - ptr;
    assign lane_we  = beat && ({1'b0, off} < WORD_N) && ({1'b0, off} < rem);
    assign lane_din = s_data[{off[SEL_W-1:0], 2'b00} +: 4];

    shader_tcache_dma_lane u_lane (
      .aclk    (aclk),
      .aresetn (aresetn),
      .we      (lane_we),
      .clr     (mask_clr),
      .din     (lane_din),
      .data    (dma_data[i]),
      .mask    (dma_mask[i])
    );
  end

endmodule

// File: tb/tb_shader_tcache_dma.sv
// Scoreboard bench for shader_tcache_dma: stimulus queues expected bursts/done pulses, a monitor checks them.
module tb_shader_tcache_dma;

  typedef struct packed {
    logic [63:0]  mask;
    logic [255:0] data;
  } burst_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_start = '0;
  logic [6:0]  cmd_count = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        tc_idle = 1'b1;
  logic        strobe;
  logic        dma_en;
  logic [3:0]  dma_data [64];
  logic [63:0] dma_mask;
  logic        busy;
  logic        done;

  burst_t      exp_q [$];
  int          done_q [$];
  logic [31:0] beats [$];
  logic [3:0]  model [64];
  int          tests = 0;
  int          fails = 0;
  int          strobe_age = -1;
  burst_t      mon_e;
  logic [63:0] hold_mask;

  shader_tcache_dma #(.TCACHE_SIZE(3), .WORD_TEXELS(8)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_count (cmd_count),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .tc_idle   (tc_idle),
    .strobe    (strobe),
    .dma_en    (dma_en),
    .dma_data  (dma_data),
    .dma_mask  (dma_mask),
    .busy      (busy),
    .done      (done)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] packed_data();
    logic [255:0] p;
    for (int i = 0; i < 64; i++) p[4*i +: 4] = dma_data[i];
    return p;
  endfunction

  // Applies a fill of the queued beats to the bench image and returns the burst it should produce.
  task automatic model_fill(input int start, input int count, output burst_t e);
    int ptr = start;
    int rem = (count > 64) ? 64 : count;
    e.mask = '0;
    foreach (beats[b]) begin
      for (int k = 0; k < 8; k++) begin
        if (k < rem) begin
          model[(ptr + k) % 64] = beats[b][4*k +: 4];
          e.mask[(ptr + k) % 64] = 1'b1;
        end
      end
      ptr = (ptr + 8) % 64;
      rem = rem - ((rem < 8) ? rem : 8);
    end
    for (int i = 0; i < 64; i++) e.data[4*i +: 4] = model[i];
  endtask

  task automatic issue_cmd(input int start, input int count);
    int t = 0;
    @(negedge aclk);
    while (!cmd_ready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_start = 6'(start);
    cmd_count = 7'(count);
    cmd_valid = 1'b1;
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input int max_gap);
    int t;
    @(negedge aclk);
    foreach (beats[b]) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(negedge aclk);
      s_valid = 1'b1;
      s_data  = beats[b];
      t = 0;
      while (!s_ready && t < 500) begin
        @(negedge aclk);
        t++;
      end
      chk("beat_accept", s_ready, 1);
      @(negedge aclk);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge aclk);
    while (!done && t < 300) begin
      @(negedge aclk);
      t++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic run_fill(input int start, input int count, input int max_gap);
    burst_t e;
    model_fill(start, count, e);
    exp_q.push_back(e);
    done_q.push_back(1);
    issue_cmd(start, count);
    send_beats(max_gap);
    wait_done();
  endtask

  // Monitor: burst contents on strobe, dma_en hold window, and done pulses.
  always @(negedge aclk) begin
    if (!aresetn) begin
      strobe_age = -1;
    end else begin
      if (strobe) begin
        chk("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("burst_mask", dma_mask, mon_e.mask);
          chk("burst_data", packed_data(), mon_e.data);
        end
        chk("dma_en_at_strobe", dma_en, 1);
        hold_mask  = dma_mask;
        strobe_age = 0;
      end else if (strobe_age >= 0) begin
        strobe_age++;
        if (strobe_age <= 3) begin
          chk("dma_en_hold", dma_en, 1);
          chk("mask_stable_hold", dma_mask, hold_mask);
        end else if (strobe_age == 4) begin
          chk("dma_en_end", dma_en, 0);
          chk("mask_cleared", dma_mask, 0);
        end else begin
          chk("done_latency", done, 1);
          strobe_age = -1;
        end
      end
      if (done) begin
        chk("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) void'(done_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    burst_t e;
    int     bad;
    for (int i = 0; i < 64; i++) model[i] = 4'h0;

    repeat (3) @(negedge aclk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_dma_en", dma_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mask", dma_mask, 0);
    chk("rst_data", packed_data(), 0);
    aresetn = 1'b1;

    // Full fill with hand-computed image: texel i = i mod 8.
    beats = {};
    for (int b = 0; b < 8; b++) beats.push_back(32'h76543210);
    for (int i = 0; i < 64; i++) model[i] = 4'(i % 8);
    e.mask = '1;
    e.data = {8{32'h76543210}};
    exp_q.push_back(e);
    done_q.push_back(1);
    issue_cmd(0, 64);
    send_beats(0);
    wait_done();
    chk("texel_tu5_tv2", dma_data[21], 4'h5);
    chk("texel_63", dma_data[63], 4'h7);

    // Partial fill wrapping 63 -> 0; lanes 2..7 of the second beat are dropped.
    beats = {32'hFEDCBA98, 32'h13579BDF};
    model_fill(60, 10, e);
    chk("wrap_mask_hand", e.mask, 64'hF000_0000_0000_003F);
    exp_q.push_back(e);
    done_q.push_back(1);
    issue_cmd(60, 10);
    send_beats(0);
    wait_done();
    chk("wrap_texel_60", dma_data[60], 4'h8);
    chk("wrap_texel_3", dma_data[3], 4'hF);
    chk("wrap_texel_5", dma_data[5], 4'hD);
    chk("wrap_texel_6_kept", dma_data[6], 4'h6);

    // Zero-count command: no stream, no strobe, done two cycles after accept.
    done_q.push_back(1);
    issue_cmd(5, 0);
    @(negedge aclk);
    chk("noop_s_ready", s_ready, 0);
    chk("noop_busy", busy, 1);
    chk("noop_done_early", done, 0);
    @(negedge aclk);
    chk("noop_done", done, 1);

    // Over-range count clamps to 64; a ninth beat is never accepted.
    beats = {};
    for (int b = 0; b < 8; b++) beats.push_back({8{4'(b)}});
    model_fill(0, 100, e);
    exp_q.push_back(e);
    done_q.push_back(1);
    issue_cmd(0, 100);
    send_beats(0);
    s_valid = 1'b1;
    s_data  = 32'hFFFF_FFFF;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (s_ready) bad++;
      @(negedge aclk);
    end
    s_valid = 1'b0;
    chk("ninth_beat_refused", bad, 0);
    chk("clamp_texel_63", dma_data[63], 4'h7);
    chk("clamp_texel_8", dma_data[8], 4'h1);

    // Random stream gaps.
    beats = {};
    for (int b = 0; b < 5; b++) beats.push_back($urandom);
    run_fill(13, 37, 3);

    // Cache busy for 20 cycles in ISSUE, with a command offered meanwhile.
    tc_idle = 1'b0;
    beats = {32'hA5A5_5A5A};
    model_fill(7, 8, e);
    exp_q.push_back(e);
    done_q.push_back(1);
    issue_cmd(7, 8);
    send_beats(0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        cmd_start = 6'd0;
        cmd_count = 7'd64;
        cmd_valid = 1'b1;
      end
      if (c == 8) cmd_valid = 1'b0;
      if (strobe || dma_en || cmd_ready) bad++;
      @(negedge aclk);
    end
    cmd_valid = 1'b0;
    chk("held_while_tc_busy", bad, 0);
    tc_idle = 1'b1;
    wait_done();

    // Reset in the second dma_en cycle aborts at once.
    beats = {32'h1234_5678};
    model_fill(0, 8, e);
    exp_q.push_back(e);
    issue_cmd(0, 8);
    send_beats(0);
    bad = 0;
    while (!strobe && bad < 100) begin
      @(negedge aclk);
      bad++;
    end
    chk("strobe_before_reset", strobe, 1);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_dma_en", dma_en, 0);
    chk("mid_rst_strobe", strobe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_mask", dma_mask, 0);
    chk("mid_rst_data", packed_data(), 0);
    for (int i = 0; i < 64; i++) model[i] = 4'h0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // Normal command after the abort.
    beats = {};
    for (int b = 0; b < 8; b++) beats.push_back(32'hFEDC_BA98);
    run_fill(0, 64, 1);
    chk("post_rst_texel_21", dma_data[21], 4'hD);

    repeat (4) @(negedge aclk);
    chk("burst_queue_drained", exp_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
